// File: rtl/sig_gen_pkg.sv
// Shared types and defaults for the waveform-ROM sequencer.
// Build option SIG_GEN_CTRL_AMP_EN enables amplitude scaling in sig_gen_ctrl.
package sig_gen_pkg;

  localparam int ADDR_W_DEFAULT = 7;
  localparam int DATA_W_DEFAULT = 8;
  localparam int ROM_DEPTH      = 1 << ADDR_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sig_gen_prescaler.sv
// Sample-rate prescaler: counts 0..div_i while enabled and flags a tick on the
// terminal count, then wraps to 0. clear_i holds the count at 0.
module sig_gen_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] div_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       terminal;

  always_comb begin
    terminal = (cnt_q == div_i);
    cnt_d    = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = terminal ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && terminal;

endmodule

// File: rtl/sig_gen_ctrl.sv
// Waveform-ROM sequencer: prescaled phase accumulator with continuous/burst modes.
// Define SIG_GEN_CTRL_AMP_EN to add the amp port and scale samples by amp/256.
module sig_gen_ctrl
  import sig_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              burst_mode,
  input  logic [ADDR_W-1:0] step,
  input  logic [7:0]        div,
  input  logic [7:0]        burst_n,
`ifdef SIG_GEN_CTRL_AMP_EN
  input  logic [7:0]        amp,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] q,
  output logic              q_vld,
  output logic              cout,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_q, addr_q, addr_d;
  logic [7:0]        div_q, burst_n_q, period_q, period_d, period_inc;
  logic              burst_mode_q;
  logic              rd_pend_q, q_vld_q, done_q;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [ADDR_W:0]   sum;
  logic              launch, presc_tick, tick, wrap, burst_end;

  sig_gen_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q != RUN),
    .en_i    (state_q == RUN),
    .div_i   (div_q),
    .tick_o  (presc_tick)
  );

  // Stop beats start, and suppresses the tick on its own cycle.
  always_comb begin
    launch     = (state_q == IDLE) && start && !stop;
    tick       = (state_q == RUN) && !stop && presc_tick;
    sum        = {1'b0, addr_q} + {1'b0, step_q};
    wrap       = sum[ADDR_W];
    period_inc = period_q + 8'd1;
    burst_end  = tick && wrap && burst_mode_q && (period_inc == burst_n_q);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    period_d = period_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = RUN;
          addr_d   = '0;
          period_d = 8'd0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (tick) begin
          addr_d = sum[ADDR_W-1:0];
          if (wrap) period_d = period_inc;
          if (burst_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pend_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      period_q <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      done_q   <= (state_q == DRAIN) && (state_d == IDLE);
    end
  end

  // Configuration is frozen at start; zero step/burst count means one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q       <= '0;
      div_q        <= 8'd0;
      burst_n_q    <= 8'd0;
      burst_mode_q <= 1'b0;
    end else if (launch) begin
      step_q       <= (step == '0) ? ADDR_W'(1) : step;
      div_q        <= div;
      burst_n_q    <= (burst_n == 8'd0) ? 8'd1 : burst_n;
      burst_mode_q <= burst_mode;
    end
  end

`ifdef SIG_GEN_CTRL_AMP_EN
  logic [7:0]          amp_q;
  logic [DATA_W+7:0]   product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_q <= 8'd0;
    end else if (launch) begin
      amp_q <= amp;
    end
  end

  always_comb begin
    product  = {8'd0, rom_q} * {{DATA_W{1'b0}}, amp_q};
    sample_d = product[DATA_W+7:8];
  end
`else
  assign sample_d = rom_q;
`endif

  // rd_pend_q marks ROM data arriving this cycle; it is captured into q next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      q_vld_q   <= 1'b0;
      sample_q  <= '0;
    end else begin
      rd_pend_q <= tick;
      q_vld_q   <= rd_pend_q;
      if (rd_pend_q) sample_q <= sample_d;
    end
  end

  assign address = addr_q;
  assign rom_rd  = tick;
  assign cout    = tick && wrap;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign q       = sample_q;
  assign q_vld   = q_vld_q;

endmodule

// File: tb/tb_sig_gen_ctrl.sv
// Directed self-checking bench for sig_gen_ctrl (default build, no amplitude port).
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_sig_gen_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, burstMode;
  logic [6:0] step;
  logic [7:0] div, burstN;
  logic [6:0] address;
  logic       romRd;
  logic [7:0] romQ;
  logic [7:0] q;
  logic       qVld, cout, busy, done;

  int testsRun = 0;
  int testsFailed = 0;

  sig_gen_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .burst_mode (burstMode),
    .step       (step),
    .div        (div),
    .burst_n    (burstN),
    .address    (address),
    .rom_rd     (romRd),
    .rom_q      (romQ),
    .q          (q),
    .q_vld      (qVld),
    .cout       (cout),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] romData(input logic [6:0] a);
    logic [7:0] t;
    t = {1'b0, a} * 8'd37 + 8'd11;
    return t;
  endfunction

  // Synchronous ROM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (romRd) romQ <= romData(address);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic bm, input logic [6:0] st, input logic [7:0] dv, input logic [7:0] bn);
    burstMode = bm;
    step      = st;
    div       = dv;
    burstN    = bn;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(tag, seen, 1);
    @(negedge clk);
  endtask

  task automatic stopRun(input string tag);
    stop = 1'b1;
    #1;
    checkOutput({tag, " no rd on stop"}, romRd, 0);
    @(negedge clk);
    stop = 1'b0;
    waitDone({tag, " done"});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " address"}, address, 0);
    checkOutput({tag, " rom_rd"}, romRd, 0);
    checkOutput({tag, " q"}, q, 0);
    checkOutput({tag, " q_vld"}, qVld, 0);
    checkOutput({tag, " cout"}, cout, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  initial begin
    int vldCnt, rdCnt, coutCnt, doneCnt, lastVld, doneCyc, dataErr;
    logic busyAtDone;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; burstMode = 1'b0;
    step = 7'd1; div = 8'd0; burstN = 8'd1;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous, step 1, div 0: a read every cycle, wrap every 128.
    applyStimulus(1'b0, 7'd1, 8'd0, 8'd1);
    for (int c = 0; c < 260; c++) begin
      checkOutput("cont busy", busy, 1);
      checkOutput("cont rom_rd", romRd, 1);
      checkOutput("cont address", address, 32'(c % 128));
      checkOutput("cont cout", cout, (c % 128) == 127);
      checkOutput("cont q_vld", qVld, c >= 2);
      if (c >= 2) checkOutput("cont q", q, romData(7'((c - 2) % 128)));
      @(negedge clk);
    end
    stopRun("cont");

    // Burst of two periods.
    applyStimulus(1'b1, 7'd1, 8'd0, 8'd2);
    vldCnt = 0; rdCnt = 0; coutCnt = 0; doneCnt = 0;
    lastVld = -1; doneCyc = -1; dataErr = 0; busyAtDone = 1'b1;
    for (int c = 0; c < 266; c++) begin
      if (romRd) rdCnt++;
      if (cout) coutCnt++;
      if (qVld) begin
        if (q !== romData(7'(vldCnt % 128))) dataErr++;
        vldCnt++;
        lastVld = c;
      end
      if (done) begin
        doneCnt++;
        doneCyc = c;
        busyAtDone = busy;
      end
      @(negedge clk);
    end
    checkOutput("burst q_vld count", vldCnt, 256);
    checkOutput("burst rom_rd count", rdCnt, 256);
    checkOutput("burst cout count", coutCnt, 2);
    checkOutput("burst q data errors", dataErr, 0);
    checkOutput("burst done count", doneCnt, 1);
    checkOutput("burst done cycle", doneCyc, 258);
    checkOutput("burst done after last vld", doneCyc, lastVld + 1);
    checkOutput("burst busy at done", busyAtDone, 0);
    checkOutput("burst busy after", busy, 0);

    // Prescaler div 3: tick on every 4th cycle, first at prescaler == 3.
    applyStimulus(1'b0, 7'd1, 8'd3, 8'd1);
    for (int c = 0; c < 24; c++) begin
      checkOutput("div3 rom_rd", romRd, (c % 4) == 3);
      checkOutput("div3 address", address, 32'(c / 4));
      @(negedge clk);
    end
    stopRun("div3");

    // Step 3: 126 wraps to 1 with cout on the 126 tick.
    applyStimulus(1'b0, 7'd3, 8'd0, 8'd1);
    for (int c = 0; c < 44; c++) begin
      if (c == 42) checkOutput("step3 address 126", address, 126);
      if (c == 43) checkOutput("step3 address 1", address, 1);
      checkOutput("step3 cout", cout, c == 42);
      @(negedge clk);
    end
    stopRun("step3");

    // Step 0 behaves as step 1.
    applyStimulus(1'b0, 7'd0, 8'd0, 8'd1);
    for (int c = 0; c < 4; c++) begin
      checkOutput("step0 address", address, c);
      @(negedge clk);
    end
    stopRun("step0");

    // Stop after ten ticks with a simultaneous start.
    applyStimulus(1'b0, 7'd1, 8'd0, 8'd1);
    for (int c = 0; c < 10; c++) @(negedge clk);
    stop = 1'b1; start = 1'b1;
    #1;
    checkOutput("stop cycle rom_rd", romRd, 0);
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    rdCnt = 0; vldCnt = 0; doneCnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (romRd) rdCnt++;
      if (qVld) vldCnt++;
      if (done) doneCnt++;
      @(negedge clk);
    end
    checkOutput("stop rd after", rdCnt, 0);
    checkOutput("stop vld at most 2", vldCnt <= 2, 1);
    checkOutput("stop done count", doneCnt, 1);
    checkOutput("stop start ignored busy", busy, 0);

    // Asynchronous reset mid-run, then a clean restart.
    applyStimulus(1'b0, 7'd1, 8'd0, 8'd1);
    for (int c = 0; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post reset done", done, 0);
    checkOutput("post reset busy", busy, 0);
    applyStimulus(1'b0, 7'd1, 8'd0, 8'd1);
    checkOutput("restart address 0", address, 0);
    checkOutput("restart rom_rd", romRd, 1);
    checkOutput("restart busy", busy, 1);
    @(negedge clk);
    checkOutput("restart address 1", address, 1);
    stopRun("restart");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
